speriph_cmd_master: RTL and testbench
=====================================

SPERIPH_CMD_MASTER -- requirements
Module: speriph_cmd_master

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 5, meaning peripheral bus id width (NB_CORES+1).
REQ-002 SHALL have parameter MASTER_ID, default 5'b10000, meaning constant id driven on per_id_o and matched on per_r_id_i.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning maximum cycles from request assertion to response (range 2..65535).
REQ-004 SHALL have ports:
  clk_i  in  1  clock, all logic rising-edge
  rst_ni  in  1  reset, synchronous, active-low
  cmd_valid_i  in  1  command offered
  cmd_ready_o  out  1  command accepted when high with cmd_valid_i
  cmd_addr_i  in  32  target address
  cmd_wen_i  in  1  1=read, 0=write (bus convention)
  cmd_wdata_i  in  32  write data
  cmd_be_i  in  4  byte enables
  rsp_valid_o  out  1  response available
  rsp_ready_i  in  1  response consumed
  rsp_rdata_o  out  32  read data
  rsp_err_o  out  1  bus error (r_opc=1)
  rsp_timeout_o  out  1  transaction aborted by timeout
  per_req_o  out  1  peripheral bus request
  per_add_o  out  32  address
  per_wen_o  out  1  write-enable (1=read)
  per_wdata_o  out  32  write data
  per_be_o  out  4  byte enables
  per_id_o  out  ID_WIDTH  requester id, constant MASTER_ID
  per_gnt_i  in  1  grant
  per_r_valid_i  in  1  response valid
  per_r_rdata_i  in  32  response data
  per_r_opc_i  in  1  response error flag
  per_r_id_i  in  ID_WIDTH  response id

Function
REQ-005 SHALL buffer commands in a 2-entry FIFO; cmd_ready_o = FIFO not full; a push while full SHALL not occur by construction.
REQ-006 SHALL issue at most one outstanding bus transaction; FSM states IDLE, REQ, WAIT_RSP, RSP.
REQ-007 IDLE: if FIFO non-empty, pop head into transaction register, go REQ next cycle (per_req_o rises one cycle after head becomes available).
REQ-008 REQ: per_req_o=1 with per_add/wen/wdata/be stable from transaction register; on per_gnt_i=1 go WAIT_RSP; per_req_o SHALL not drop before gnt except on timeout.
REQ-009 WAIT_RSP: per_req_o=0; on per_r_valid_i=1 and per_r_id_i==MASTER_ID capture rdata (writes: capture as-is) and r_opc into response register, go RSP.
REQ-010 per_r_valid_i arriving in the same cycle as per_gnt_i SHALL be ignored (response is at least one cycle after grant).
REQ-011 per_r_valid_i with id mismatch, or in IDLE/REQ/RSP, SHALL be ignored without state change.
REQ-012 RSP: rsp_valid_o=1, outputs held stable until rsp_ready_i=1; then go IDLE (or REQ directly if FIFO non-empty, popping head same cycle).
REQ-013 Timeout counter (16 bit) SHALL clear on REQ entry, increment each cycle in REQ and WAIT_RSP, saturate; when it equals TIMEOUT go RSP with rsp_timeout_o=1, rsp_err_o=1, rsp_rdata_o=0, per_req_o=0 that cycle.
REQ-014 Response and timeout in the same cycle: response SHALL win (timeout_o=0).
REQ-015 Commands SHALL be accepted in any state, including RSP backpressure, until FIFO full.
REQ-016 per_id_o SHALL equal MASTER_ID at all times.

Reset
REQ-017 rst_ni=0 at a clock edge SHALL empty the FIFO, force IDLE, clear counter and response register; mid-transaction reset abandons the transaction silently.
REQ-018 During/after reset: cmd_ready_o=1 (after first reset edge), rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, rsp_timeout_o=0, per_req_o=0, per_add_o=0, per_wen_o=1, per_wdata_o=0, per_be_o=0.

Verification
REQ-019 Read 0x1020_0400, gnt after 2 cycles, r_valid 1 cycle later with rdata 0xCAFE_0001, r_opc=0 -> rsp_valid_o=1, rdata 0xCAFE_0001, err=0, timeout=0.
REQ-020 Write 0x1020_0000 data 0x5, be 0xF, gnt same cycle as req, r_opc=1 -> rsp err=1, per_req_o high exactly 1 cycle.
REQ-021 Three back-to-back commands, rsp_ready_i=0 -> cmd_ready_o low after 2 accepted beyond the active one; transactions complete in order once rsp_ready_i=1.
REQ-022 TIMEOUT=8, gnt never asserted -> per_req_o drops after 8 cycles, rsp timeout=1, err=1, rdata=0; late r_valid ignored.
REQ-023 r_valid with r_id=5'b00001 during WAIT_RSP -> ignored; matching response 3 cycles later captured.
REQ-024 rst_ni=0 in WAIT_RSP -> next cycle IDLE, FIFO empty, all outputs at REQ-018 values.

Source files
------------

// File: rtl/speriph_cmd_master.sv
// Single-outstanding peripheral bus master: a 2-deep command FIFO feeds a
// REQ / WAIT_RSP / RSP sequencer with a saturating per-transaction timeout.
module speriph_cmd_master #(
  parameter int unsigned          ID_WIDTH  = 5,
  parameter logic [ID_WIDTH-1:0]  MASTER_ID = 5'b10000,
  parameter int unsigned          TIMEOUT   = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [31:0]         cmd_addr_i,
  input  logic                cmd_wen_i,
  input  logic [31:0]         cmd_wdata_i,
  input  logic [3:0]          cmd_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,
  output logic                per_req_o,
  output logic [31:0]         per_add_o,
  output logic                per_wen_o,
  output logic [31:0]         per_wdata_o,
  output logic [3:0]          per_be_o,
  output logic [ID_WIDTH-1:0] per_id_o,
  input  logic                per_gnt_i,
  input  logic                per_r_valid_i,
  input  logic [31:0]         per_r_rdata_i,
  input  logic                per_r_opc_i,
  input  logic [ID_WIDTH-1:0] per_r_id_i
);

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RSP} state_t;

  localparam cmd_t        TXN_RESET   = '{addr: 32'h0, wen: 1'b1, wdata: 32'h0, be: 4'h0};
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  // Command FIFO
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       push;
  logic       pop;
  logic       fifo_nonempty;
  cmd_t       cmd_in;
  cmd_t       head;

  assign cmd_in        = '{addr: cmd_addr_i, wen: cmd_wen_i, wdata: cmd_wdata_i, be: cmd_be_i};
  assign cmd_ready_o   = (count_reg != 2'd2);
  assign push          = cmd_valid_i && cmd_ready_o;
  assign fifo_nonempty = (count_reg != 2'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_fifo
      cmd_t entry_reg;
      always_ff @(posedge clk_i) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= cmd_in;
        end
      end
    end
  endgenerate

  assign head = rd_ptr_reg ? gen_fifo[1].entry_reg : gen_fifo[0].entry_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Transaction sequencer
  state_t      state_reg, state_next;
  cmd_t        txn_reg, txn_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [31:0] rsp_rdata_reg, rsp_rdata_next;
  logic        rsp_err_reg, rsp_err_next;
  logic        rsp_timeout_reg, rsp_timeout_next;
  logic        issue_req;
  logic        timeout_hit;
  logic        rsp_match;

  assign timeout_hit = (cnt_reg == TIMEOUT_CNT);
  assign rsp_match   = per_r_valid_i && (per_r_id_i == MASTER_ID);

  always_comb begin
    state_next       = state_reg;
    txn_next         = txn_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_err_next     = rsp_err_reg;
    rsp_timeout_next = rsp_timeout_reg;
    pop              = 1'b0;
    issue_req        = 1'b0;
    cnt_next         = cnt_reg;
    if (((state_reg == REQ) || (state_reg == WAIT_RSP)) && (cnt_reg != 16'hFFFF)) begin
      cnt_next = cnt_reg + 16'd1;
    end

    case (state_reg)
      IDLE: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          txn_next   = head;
          cnt_next   = 16'd0;
          state_next = REQ;
        end
      end
      REQ: begin
        if (timeout_hit) begin
          rsp_rdata_next   = 32'h0;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          state_next       = RSP;
        end else begin
          issue_req = 1'b1;
          if (per_gnt_i) state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A matching response outranks a timeout landing in the same cycle.
        if (rsp_match) begin
          rsp_rdata_next   = per_r_rdata_i;
          rsp_err_next     = per_r_opc_i;
          rsp_timeout_next = 1'b0;
          state_next       = RSP;
        end else if (timeout_hit) begin
          rsp_rdata_next   = 32'h0;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          state_next       = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          if (fifo_nonempty) begin
            pop        = 1'b1;
            txn_next   = head;
            cnt_next   = 16'd0;
            state_next = REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      txn_reg         <= TXN_RESET;
      cnt_reg         <= 16'd0;
      rsp_rdata_reg   <= 32'h0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      txn_reg         <= txn_next;
      cnt_reg         <= cnt_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  assign rsp_valid_o   = (state_reg == RSP);
  assign rsp_rdata_o   = rsp_rdata_reg;
  assign rsp_err_o     = rsp_err_reg;
  assign rsp_timeout_o = rsp_timeout_reg;

  assign per_req_o   = issue_req;
  assign per_add_o   = txn_reg.addr;
  assign per_wen_o   = txn_reg.wen;
  assign per_wdata_o = txn_reg.wdata;
  assign per_be_o    = txn_reg.be;
  assign per_id_o    = MASTER_ID;

endmodule

// File: tb/tb_speriph_cmd_master.sv
// Directed bench for speriph_cmd_master: vector table of single transactions
// plus hand-written sequences for backpressure, id filtering, timeout and reset.
module tb_speriph_cmd_master;

  localparam int          ID_WIDTH  = 5;
  localparam logic [4:0]  MASTER_ID = 5'b10000;
  localparam int          TIMEOUT   = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i;
  logic        cmd_wen_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_be_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        per_req_o;
  logic [31:0] per_add_o;
  logic        per_wen_o;
  logic [31:0] per_wdata_o;
  logic [3:0]  per_be_o;
  logic [4:0]  per_id_o;
  logic        per_gnt_i;
  logic        per_r_valid_i;
  logic [31:0] per_r_rdata_i;
  logic        per_r_opc_i;
  logic [4:0]  per_r_id_i;

  speriph_cmd_master #(.ID_WIDTH(ID_WIDTH), .MASTER_ID(MASTER_ID), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_wen_i(cmd_wen_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .per_req_o(per_req_o), .per_add_o(per_add_o), .per_wen_o(per_wen_o),
    .per_wdata_o(per_wdata_o), .per_be_o(per_be_o), .per_id_o(per_id_o),
    .per_gnt_i(per_gnt_i), .per_r_valid_i(per_r_valid_i), .per_r_rdata_i(per_r_rdata_i),
    .per_r_opc_i(per_r_opc_i), .per_r_id_i(per_r_id_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gnt_wait;
    int          rv_wait;
    logic [31:0] rdata;
    logic        opc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_req;
  } vec_t;

  vec_t        vecs[6];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic        rv_pending;
  logic [31:0] rv_data;
  logic [31:0] bb_addr[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive_cmd(input logic [31:0] addr, input logic wen,
                           input logic [31:0] wdata, input logic [3:0] be);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = addr;
    cmd_wen_i   = wen;
    cmd_wdata_i = wdata;
    cmd_be_i    = be;
  endtask

  // Grant every request at once and answer one cycle later with addr+0x100.
  task automatic auto_bus();
    per_r_valid_i = rv_pending;
    per_r_rdata_i = rv_data;
    per_r_opc_i   = 1'b0;
    per_r_id_i    = MASTER_ID;
    rv_pending    = 1'b0;
    per_gnt_i     = per_req_o;
    if (per_req_o) begin
      rv_pending = 1'b1;
      rv_data    = per_add_o + 32'h100;
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int   req_cnt;
    int   since;
    bit   gnt_seen;
    bit   got;
    bit   bus_ok;
    @(negedge clk_i);
    check($sformatf("vec%0d_cmd_ready", n), cmd_ready_o, 1'b1);
    drive_cmd(v.addr, v.wen, v.wdata, v.be);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    req_cnt = 0; since = 0; gnt_seen = 0; got = 0; bus_ok = 1;
    for (int cyc = 0; cyc < 60 && !got; cyc++) begin
      if (rsp_valid_o) begin
        got = 1;
      end else begin
        if (per_req_o) begin
          req_cnt++;
          if (per_add_o !== v.addr || per_wen_o !== v.wen ||
              per_wdata_o !== v.wdata || per_be_o !== v.be) bus_ok = 0;
          per_gnt_i     = (req_cnt == v.gnt_wait + 1);
          per_r_valid_i = 1'b0;
          if (per_gnt_i) gnt_seen = 1;
        end else begin
          per_gnt_i = 1'b0;
          if (gnt_seen) since++;
          per_r_valid_i = gnt_seen && (since == v.rv_wait);
          per_r_rdata_i = v.rdata;
          per_r_opc_i   = v.opc;
          per_r_id_i    = MASTER_ID;
        end
        @(negedge clk_i);
      end
    end
    per_gnt_i     = 1'b0;
    per_r_valid_i = 1'b0;
    check($sformatf("vec%0d_rsp_seen", n), 32'(got), 32'd1);
    check($sformatf("vec%0d_req_cycles", n), 32'(req_cnt), 32'(v.exp_req));
    check($sformatf("vec%0d_bus_fields", n), 32'(bus_ok), 32'd1);
    check($sformatf("vec%0d_rdata", n), rsp_rdata_o, v.exp_rdata);
    check($sformatf("vec%0d_err", n), rsp_err_o, v.exp_err);
    check($sformatf("vec%0d_timeout", n), rsp_timeout_o, v.exp_to);
    $display("vec %0d addr=%h wen=%0d rdata=%h err=%0d timeout=%0d req_cycles=%0d",
             n, v.addr, v.wen, rsp_rdata_o, rsp_err_o, rsp_timeout_o, req_cnt);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check($sformatf("vec%0d_rsp_released", n), rsp_valid_o, 1'b0);
  endtask

  initial begin
    int  idx;
    int  accepted;
    int  n;
    bit  seen;
    bit  quiet;

    vecs[0] = '{addr: 32'h1020_0400, wen: 1'b1, wdata: 32'h0, be: 4'hF, gnt_wait: 2, rv_wait: 1,
                rdata: 32'hCAFE_0001, opc: 1'b0, exp_rdata: 32'hCAFE_0001, exp_err: 1'b0, exp_to: 1'b0, exp_req: 3};
    vecs[1] = '{addr: 32'h1020_0000, wen: 1'b0, wdata: 32'h5, be: 4'hF, gnt_wait: 0, rv_wait: 1,
                rdata: 32'hDEAD_BEEF, opc: 1'b1, exp_rdata: 32'hDEAD_BEEF, exp_err: 1'b1, exp_to: 1'b0, exp_req: 1};
    vecs[2] = '{addr: 32'h2000_0010, wen: 1'b1, wdata: 32'h0, be: 4'h3, gnt_wait: 0, rv_wait: 8,
                rdata: 32'h1234_5678, opc: 1'b0, exp_rdata: 32'h1234_5678, exp_err: 1'b0, exp_to: 1'b0, exp_req: 1};
    vecs[3] = '{addr: 32'h2000_0020, wen: 1'b1, wdata: 32'h0, be: 4'hF, gnt_wait: 0, rv_wait: 9,
                rdata: 32'h1111_2222, opc: 1'b0, exp_rdata: 32'h0, exp_err: 1'b1, exp_to: 1'b1, exp_req: 1};
    vecs[4] = '{addr: 32'h3000_0000, wen: 1'b1, wdata: 32'h0, be: 4'hF, gnt_wait: 20, rv_wait: 1,
                rdata: 32'h3333_4444, opc: 1'b0, exp_rdata: 32'h0, exp_err: 1'b1, exp_to: 1'b1, exp_req: 8};
    vecs[5] = '{addr: 32'h0000_0004, wen: 1'b0, wdata: 32'hA5A5_0000, be: 4'h5, gnt_wait: 3, rv_wait: 2,
                rdata: 32'h0, opc: 1'b0, exp_rdata: 32'h0, exp_err: 1'b0, exp_to: 1'b0, exp_req: 4};
    bb_addr[0] = 32'h4000_0000; bb_addr[1] = 32'h4000_0010;
    bb_addr[2] = 32'h4000_0020; bb_addr[3] = 32'h4000_0030;

    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_wen_i = 1'b1; cmd_wdata_i = '0;
    cmd_be_i = '0; rsp_ready_i = 1'b0; per_gnt_i = 1'b0; per_r_valid_i = 1'b0;
    per_r_rdata_i = '0; per_r_opc_i = 1'b0; per_r_id_i = '0; rv_pending = 1'b0; rv_data = '0;

    repeat (3) @(negedge clk_i);
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_per_req", per_req_o, 1'b0);
    check("rst_per_wen", per_wen_o, 1'b1);
    check("rst_per_add", per_add_o, 32'h0);
    check("rst_per_id", per_id_o, MASTER_ID);
    rst_ni = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // r_valid alongside the grant and a foreign-id response are both ignored.
    @(negedge clk_i);
    drive_cmd(32'h3000_1000, 1'b1, 32'h0, 4'hF);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      seen = per_req_o;
    end
    check("idf_req_seen", 32'(seen), 32'd1);
    per_gnt_i = 1'b1; per_r_valid_i = 1'b1; per_r_id_i = MASTER_ID; per_r_rdata_i = 32'hBAD0_0000;
    @(negedge clk_i);
    per_gnt_i = 1'b0; per_r_valid_i = 1'b1; per_r_id_i = 5'b00001; per_r_rdata_i = 32'hBAD0_0001;
    @(negedge clk_i);
    per_r_valid_i = 1'b0;
    check("idf_ignored", rsp_valid_o, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    per_r_valid_i = 1'b1; per_r_id_i = MASTER_ID; per_r_rdata_i = 32'h600D_0023; per_r_opc_i = 1'b0;
    @(negedge clk_i);
    per_r_valid_i = 1'b0;
    check("idf_rsp_valid", rsp_valid_o, 1'b1);
    check("idf_rdata", rsp_rdata_o, 32'h600D_0023);
    check("idf_timeout", rsp_timeout_o, 1'b0);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;

    // Back-to-back commands under response backpressure.
    idx = 0; accepted = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      auto_bus();
      if (idx < 4) begin
        drive_cmd(bb_addr[idx], 1'b1, 32'h0, 4'hF);
        if (cmd_ready_o) begin accepted++; idx++; end
      end else cmd_valid_i = 1'b0;
    end
    check("bb_accepted_blocked", 32'(accepted), 32'd3);
    check("bb_cmd_ready_low", cmd_ready_o, 1'b0);
    check("bb_rsp_held", rsp_valid_o, 1'b1);
    check("bb_rsp_held_data", rsp_rdata_o, bb_addr[0] + 32'h100);
    rsp_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      if (c > 0) @(negedge clk_i);
      auto_bus();
      if (rsp_valid_o) begin
        check($sformatf("bb_order%0d", n), rsp_rdata_o, bb_addr[n] + 32'h100);
        $display("bb rsp %0d rdata=%h", n, rsp_rdata_o);
        n++;
      end
      if (idx < 4) begin
        drive_cmd(bb_addr[idx], 1'b1, 32'h0, 4'hF);
        if (cmd_ready_o) begin accepted++; idx++; end
      end else cmd_valid_i = 1'b0;
    end
    @(negedge clk_i);
    rsp_ready_i = 1'b0; cmd_valid_i = 1'b0; per_gnt_i = 1'b0; per_r_valid_i = 1'b0;
    check("bb_all_rsp", 32'(n), 32'd4);
    check("bb_all_accepted", 32'(accepted), 32'd4);

    // Timeout with no grant; a late response must not disturb the held result.
    @(negedge clk_i);
    drive_cmd(32'h5000_0000, 1'b1, 32'h0, 4'hF);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk_i);
      seen = rsp_valid_o;
    end
    check("to_rsp_seen", 32'(seen), 32'd1);
    per_r_valid_i = 1'b1; per_r_id_i = MASTER_ID; per_r_rdata_i = 32'hFFFF_FFFF; per_r_opc_i = 1'b0;
    @(negedge clk_i);
    per_r_valid_i = 1'b0;
    check("to_late_valid", rsp_valid_o, 1'b1);
    check("to_late_rdata", rsp_rdata_o, 32'h0);
    check("to_late_flag", rsp_timeout_o, 1'b1);
    check("to_late_err", rsp_err_o, 1'b1);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0; per_r_valid_i = 1'b1;
    @(negedge clk_i);
    per_r_valid_i = 1'b0;
    check("to_idle_rsp", rsp_valid_o, 1'b0);
    check("to_idle_req", per_req_o, 1'b0);

    // Reset while waiting for a response, with a second command queued.
    drive_cmd(32'h6000_0000, 1'b0, 32'h1234, 4'hC);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      seen = per_req_o;
    end
    check("rw_req_seen", 32'(seen), 32'd1);
    per_gnt_i = 1'b1;
    @(negedge clk_i);
    per_gnt_i = 1'b0;
    drive_cmd(32'h6000_0004, 1'b1, 32'h0, 4'hF);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("rw_cmd_ready", cmd_ready_o, 1'b1);
    check("rw_rsp_valid", rsp_valid_o, 1'b0);
    check("rw_rsp_rdata", rsp_rdata_o, 32'h0);
    check("rw_rsp_err", rsp_err_o, 1'b0);
    check("rw_rsp_timeout", rsp_timeout_o, 1'b0);
    check("rw_per_req", per_req_o, 1'b0);
    check("rw_per_add", per_add_o, 32'h0);
    check("rw_per_wen", per_wen_o, 1'b1);
    check("rw_per_wdata", per_wdata_o, 32'h0);
    check("rw_per_be", per_be_o, 4'h0);
    rst_ni = 1'b1;
    per_r_valid_i = 1'b1; per_r_id_i = MASTER_ID; per_r_rdata_i = 32'h7777_7777;
    quiet = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      per_r_valid_i = 1'b0;
      if (per_req_o || rsp_valid_o) quiet = 0;
    end
    check("rw_fifo_empty", 32'(quiet), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
